adder_resp_checker: RTL

Response-side checker for the adder test bench: the counterpart of the stimulus generator that drives incrementing operands into the adder under test. It samples the applied operands and carry-in, delays them to match the DUT latency, and compares the DUT sum/carry-out against the golden A+B+Ci. It counts errors, records the first failure, checks that A advances as an incrementing modulo-2^WIDTH counter, and reports pass/fail after a fixed number of vectors.

---
 rtl/adder_resp_checker.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/adder_resp_checker.sv
// Response checker for an adder under test: delays sampled operands to match DUT latency,
// compares {Co,S} against A+B+Ci, tracks errors, first failure and operand-A sequencing.
module adder_resp_checker #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned LATENCY     = 1,
    parameter int unsigned NUM_VECTORS = 16,
    parameter int unsigned ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    input  logic [WIDTH-1:0] S,
    input  logic             Co,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       vec_count,
    output logic [ERR_W-1:0] err_count,
    output logic             seq_err,
    output logic             first_err_valid,
    output logic [WIDTH-1:0] first_err_A,
    output logic [WIDTH-1:0] first_err_B,
    output logic [WIDTH:0]   first_err_S
);

    localparam int unsigned SUM_W = WIDTH + 1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [LATENCY-1:0] dl_valid_q;
    logic [WIDTH-1:0]   dl_a_q  [LATENCY];
    logic [WIDTH-1:0]   dl_b_q  [LATENCY];
    logic               dl_ci_q [LATENCY];

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [7:0]       vec_count_q, vec_count_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             seq_err_q, seq_err_d;
    logic             fe_valid_q, fe_valid_d;
    logic [WIDTH-1:0] fe_a_q, fe_a_d;
    logic [WIDTH-1:0] fe_b_q, fe_b_d;
    logic [WIDTH:0]   fe_s_q, fe_s_d;
    logic [WIDTH-1:0] prev_a_q, prev_a_d;
    logic             have_prev_q, have_prev_d;

    logic             accept;
    logic             compare;
    logic             mismatch;
    logic             seq_bad;
    logic             flush;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH:0]   exp_sum;
    logic [WIDTH:0]   got_sum;

    // Datapath decode around the head of the delay line.
    assign accept   = en && (state_q != DONE);
    assign compare  = dl_valid_q[LATENCY-1] && (state_q == RUN);
    assign exp_sum  = SUM_W'(dl_a_q[LATENCY-1]) + SUM_W'(dl_b_q[LATENCY-1])
                    + SUM_W'(dl_ci_q[LATENCY-1]);
    assign got_sum  = {Co, S};
    assign mismatch = compare && (exp_sum != got_sum);
    assign a_next   = prev_a_q + WIDTH'(1);
    assign seq_bad  = accept && have_prev_q && (A != a_next);

    always_comb begin
        state_d     = state_q;
        vec_count_d = vec_count_q;
        err_count_d = err_count_q;
        seq_err_d   = seq_err_q;
        fe_valid_d  = fe_valid_q;
        fe_a_d      = fe_a_q;
        fe_b_d      = fe_b_q;
        fe_s_d      = fe_s_q;
        prev_a_d    = prev_a_q;
        have_prev_d = have_prev_q;
        pass_d      = pass_q;
        flush       = 1'b0;

        if (accept) begin
            if (seq_bad) begin
                seq_err_d = 1'b1;
            end
            prev_a_d    = A;
            have_prev_d = 1'b1;
        end

        if (compare) begin
            vec_count_d = vec_count_q + 8'd1;
            if (mismatch) begin
                if (err_count_q != ERR_MAX) begin
                    err_count_d = err_count_q + ERR_W'(1);
                end
                // Only the first failure is kept for post-mortem.
                if (!fe_valid_q) begin
                    fe_valid_d = 1'b1;
                    fe_a_d     = dl_a_q[LATENCY-1];
                    fe_b_d     = dl_b_q[LATENCY-1];
                    fe_s_d     = got_sum;
                end
            end
        end

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (compare && (vec_count_d == 8'(NUM_VECTORS))) begin
                    state_d = DONE;
                    flush   = 1'b1;
                    pass_d  = (err_count_d == '0) && !seq_err_d;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            vec_count_q <= '0;
            err_count_q <= '0;
            seq_err_q   <= 1'b0;
            fe_valid_q  <= 1'b0;
            fe_a_q      <= '0;
            fe_b_q      <= '0;
            fe_s_q      <= '0;
            prev_a_q    <= '0;
            have_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            vec_count_q <= vec_count_d;
            err_count_q <= err_count_d;
            seq_err_q   <= seq_err_d;
            fe_valid_q  <= fe_valid_d;
            fe_a_q      <= fe_a_d;
            fe_b_q      <= fe_b_d;
            fe_s_q      <= fe_s_d;
            prev_a_q    <= prev_a_d;
            have_prev_q <= have_prev_d;
        end
    end

    // Latency-matching delay line; in-flight entries are dropped on reset and on completion.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            dl_valid_q <= '0;
        end else if (state_q != DONE) begin
            for (int i = int'(LATENCY) - 1; i > 0; i--) begin
                dl_valid_q[i] <= dl_valid_q[i-1];
                dl_a_q[i]     <= dl_a_q[i-1];
                dl_b_q[i]     <= dl_b_q[i-1];
                dl_ci_q[i]    <= dl_ci_q[i-1];
            end
            dl_valid_q[0] <= accept;
            dl_a_q[0]     <= A;
            dl_b_q[0]     <= B;
            dl_ci_q[0]    <= Ci;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign vec_count       = vec_count_q;
    assign err_count       = err_count_q;
    assign seq_err         = seq_err_q;
    assign first_err_valid = fe_valid_q;
    assign first_err_A     = fe_a_q;
    assign first_err_B     = fe_b_q;
    assign first_err_S     = fe_s_q;

endmodule
